mac_tx_arbiter: RTL
===================

Name: mac_tx_arbiter

Overview:
- Packet-granular round-robin arbiter sharing the MAC engine's 64-bit AXI-Stream TX slave port (s_tx_axis_*) between two packet sources: s0 (CPU/DMA path) and s1 (loopback/test generator).
- Once granted, a source owns the MAC TX port until its tlast beat is accepted. Packets are never interleaved.
- Keeps per-source packet counters for software/debug visibility.

Parameters:
- DATA_WIDTH, 64, tdata width of all streams.
- KEEP_WIDTH, 8, tkeep width (DATA_WIDTH/8).
- CNT_WIDTH, 16, width of the packet counters.
- TIMEOUT_CYCLES, 256, stall limit; used only with the optional feature.

Ports:
- clk  in  1  single clock for all logic.
- resetn  in  1  asynchronous active-low reset.
- s0_axis_tdata  in  DATA_WIDTH  source 0 data.
- s0_axis_tkeep  in  KEEP_WIDTH  source 0 byte enables.
- s0_axis_tvalid  in  1  source 0 valid.
- s0_axis_tuser  in  1  source 0 sideband, passed through.
- s0_axis_tlast  in  1  source 0 end of packet.
- s0_axis_tready  out  1  source 0 ready.
- s1_axis_tdata / s1_axis_tkeep / s1_axis_tvalid / s1_axis_tuser / s1_axis_tlast  in  as s0  source 1 stream.
- s1_axis_tready  out  1  source 1 ready.
- m_axis_tdata  out  DATA_WIDTH  to MAC s_tx_axis_tdata.
- m_axis_tkeep  out  KEEP_WIDTH  to MAC tkeep.
- m_axis_tvalid  out  1  to MAC tvalid.
- m_axis_tuser  out  1  to MAC tuser.
- m_axis_tlast  out  1  to MAC tlast.
- m_axis_tready  in  1  from MAC s_tx_axis_tready.
- pkt_cnt0  out  CNT_WIDTH  packets completed from s0.
- pkt_cnt1  out  CNT_WIDTH  packets completed from s1.
- grant  out  2  one-hot current owner; 00 when idle.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, rr_ptr=0 (s0 has priority), pkt_cnt0=pkt_cnt1=0.
  - All m_axis_* outputs 0; s0/s1_axis_tready=0; grant=00.
- States: IDLE, GNT0, GNT1 (plus ABORT, FLUSH with the optional feature).
- IDLE:
  - All tready=0, m_axis_tvalid=0, m_axis_tdata/tkeep/tuser/tlast=0.
  - If only sX_tvalid=1, go to GNTX.
  - If both are valid, go to GNT[rr_ptr].
  - Arbitration latency: exactly 1 cycle; the first beat can transfer in the cycle after the request is seen.
- GNTX:
  - m_axis_* = sX_axis_*, a combinational mux with no added latency.
  - sX_axis_tready = m_axis_tready; the other source's tready=0.
  - grant = one-hot X.
- Packet end in GNTX: on a beat with sX_tvalid & m_axis_tready & sX_tlast:
  - pkt_cntX increments, wrapping from 2^CNT_WIDTH-1 to 0.
  - rr_ptr = ~X; next state IDLE.
  - This gives one mandatory idle bubble between packets.
- Single-beat packets (tlast on the first beat) are legal and handled identically.
- m_axis_tready low in GNTX: the beat is held; the source must keep its data stable (AXIS rule). The arbiter never drops a beat.
- Request withdrawal in IDLE (a tvalid pulse that drops before grant): legal. The source's state is re-evaluated each cycle; a source that is granted and then drops tvalid simply stalls in GNTX.
- Reset mid-packet: immediate return to IDLE. The MAC sees a truncated packet, which is acceptable.
- tuser passes through unmodified in GNTX.

Optional Feature:
- Macro: MAC_TX_ARB_TIMEOUT_EN.
- With the macro defined:
  - A stall counter counts consecutive GNTX cycles with sX_tvalid=0; it clears on any sX_tvalid=1.
  - When the counter reaches TIMEOUT_CYCLES, go to ABORT.
  - ABORT: drive m_axis_tvalid=1, tdata=0, tkeep=8'h01, tlast=1, tuser=1 (errored frame). Both source treadys=0. Hold until m_axis_tready=1, then go to FLUSH.
  - FLUSH: sX_tready=1 and m_axis_tvalid=0. Discard beats until an sX beat with tlast, then go to IDLE with rr_ptr=~X.
  - Aborted packets are not counted in pkt_cntX.
- Without the macro: no stall counter, ABORT/FLUSH do not exist, and a stalled owner holds the port indefinitely.

Test Plan:
- Single source: s0 sends a 4-beat packet (tdata 1..4, last tkeep 8'h0F) with m_axis_tready=1 -> m_axis shows beats 1..4 in order, tlast on beat 4, pkt_cnt0=1, grant 00→01→00.
- Contention: s0 and s1 both valid from reset with 3-beat packets each -> s0 packet, 1 idle cycle, s1 packet, then s0 again; pkt_cnt0=2, pkt_cnt1=1 after three packets.
- Backpressure: m_axis_tready toggles 1,0,0,1 during a 5-beat s1 packet -> s1_tready mirrors it, no beat lost or duplicated, output data matches input order.
- Lock: s1 asserts valid mid-way through an s0 packet -> s1_tready stays 0 until s0's tlast is accepted; s1 is granted in the cycle after the bubble.
- Reset mid-packet: resetn pulsed low on beat 2 of 4 -> outputs 0 immediately, pkt_cnt0=0, grant=00; a new packet afterwards arbitrates from s0.
- Timeout (MAC_TX_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): s0 stalls after beat 2 -> after 8 idle cycles the MAC sees tlast=1, tuser=1, tkeep=8'h01; the remaining s0 beats are drained without appearing on m_axis; pkt_cnt0 is unchanged.

Source files
------------

// File: rtl/mac_tx_arbiter.sv
// mac_tx_arbiter: packet-granular round-robin arbiter that shares the MAC TX
// AXI-Stream port between two sources (s0 = CPU/DMA, s1 = loopback/testgen).
// A granted source owns the port until its tlast beat is accepted. An idle
// bubble separates packets.
// Optional stall timeout with errored-frame abort: define MAC_TX_ARB_TIMEOUT_EN.
module mac_tx_arbiter #(
  parameter int DATA_WIDTH     = 64,
  parameter int KEEP_WIDTH     = 8,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s0_axis_tkeep,
  input  logic                  s0_axis_tvalid,
  input  logic                  s0_axis_tuser,
  input  logic                  s0_axis_tlast,
  output logic                  s0_axis_tready,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s1_axis_tkeep,
  input  logic                  s1_axis_tvalid,
  input  logic                  s1_axis_tuser,
  input  logic                  s1_axis_tlast,
  output logic                  s1_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [CNT_WIDTH-1:0]  pkt_cnt0,
  output logic [CNT_WIDTH-1:0]  pkt_cnt1,
  output logic [1:0]            grant
);

  // Elaboration-time sanity checks on the configuration.
  if (KEEP_WIDTH * 8 != DATA_WIDTH) begin : g_bad_keep
    $error("mac_tx_arbiter: KEEP_WIDTH must be DATA_WIDTH/8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mac_tx_arbiter: TIMEOUT_CYCLES must be >= 1");
  end

`ifdef MAC_TX_ARB_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, GNT0, GNT1, ABORT, FLUSH} state_e;
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic               owner_q, owner_d;   // source being aborted/flushed
  logic [STALL_W-1:0] stall_q, stall_d;   // consecutive owner-idle cycles
`else
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;
`endif

  state_e               state_q, state_d;
  logic                 rr_ptr_q, rr_ptr_d;   // 0: s0 wins a tie, 1: s1 wins
  logic [CNT_WIDTH-1:0] pkt_cnt0_q, pkt_cnt0_d;
  logic [CNT_WIDTH-1:0] pkt_cnt1_q, pkt_cnt1_d;

  // Next-state: arbitration in IDLE, packet-end detection while granted.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    pkt_cnt0_d = pkt_cnt0_q;
    pkt_cnt1_d = pkt_cnt1_q;
`ifdef MAC_TX_ARB_TIMEOUT_EN
    owner_d    = owner_q;
    stall_d    = '0;
`endif
    case (state_q)
      IDLE: begin
        if (s0_axis_tvalid && s1_axis_tvalid) state_d = rr_ptr_q ? GNT1 : GNT0;
        else if (s0_axis_tvalid)              state_d = GNT0;
        else if (s1_axis_tvalid)              state_d = GNT1;
      end
      GNT0: begin
        if (s0_axis_tvalid && m_axis_tready && s0_axis_tlast) begin
          pkt_cnt0_d = pkt_cnt0_q + CNT_WIDTH'(1);
          rr_ptr_d   = 1'b1;
          state_d    = IDLE;
        end
`ifdef MAC_TX_ARB_TIMEOUT_EN
        else if (!s0_axis_tvalid) begin
          stall_d = stall_q + STALL_W'(1);
          if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
            owner_d = 1'b0;
            state_d = ABORT;
          end
        end
`endif
      end
      GNT1: begin
        if (s1_axis_tvalid && m_axis_tready && s1_axis_tlast) begin
          pkt_cnt1_d = pkt_cnt1_q + CNT_WIDTH'(1);
          rr_ptr_d   = 1'b0;
          state_d    = IDLE;
        end
`ifdef MAC_TX_ARB_TIMEOUT_EN
        else if (!s1_axis_tvalid) begin
          stall_d = stall_q + STALL_W'(1);
          if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
            owner_d = 1'b1;
            state_d = ABORT;
          end
        end
`endif
      end
`ifdef MAC_TX_ARB_TIMEOUT_EN
      ABORT: begin
        if (m_axis_tready) state_d = FLUSH;
      end
      FLUSH: begin
        // Drain the stalled source up to its tlast; the packet is not counted.
        if (owner_q ? (s1_axis_tvalid && s1_axis_tlast)
                    : (s0_axis_tvalid && s0_axis_tlast)) begin
          rr_ptr_d = ~owner_q;
          state_d  = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State registers; async reset drops any packet in flight back to IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 1'b0;
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
`ifdef MAC_TX_ARB_TIMEOUT_EN
      owner_q    <= 1'b0;
      stall_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      pkt_cnt0_q <= pkt_cnt0_d;
      pkt_cnt1_q <= pkt_cnt1_d;
`ifdef MAC_TX_ARB_TIMEOUT_EN
      owner_q    <= owner_d;
      stall_q    <= stall_d;
`endif
    end
  end

  // Datapath: zero-latency mux selected by the registered owner state.
  always_comb begin
    m_axis_tdata   = '0;
    m_axis_tkeep   = '0;
    m_axis_tvalid  = 1'b0;
    m_axis_tuser   = 1'b0;
    m_axis_tlast   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    grant          = 2'b00;
    case (state_q)
      GNT0: begin
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tkeep   = s0_axis_tkeep;
        m_axis_tvalid  = s0_axis_tvalid;
        m_axis_tuser   = s0_axis_tuser;
        m_axis_tlast   = s0_axis_tlast;
        s0_axis_tready = m_axis_tready;
        grant          = 2'b01;
      end
      GNT1: begin
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tkeep   = s1_axis_tkeep;
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tuser   = s1_axis_tuser;
        m_axis_tlast   = s1_axis_tlast;
        s1_axis_tready = m_axis_tready;
        grant          = 2'b10;
      end
`ifdef MAC_TX_ARB_TIMEOUT_EN
      ABORT: begin
        // Single errored terminating beat so the MAC closes the frame.
        m_axis_tkeep  = KEEP_WIDTH'(1);
        m_axis_tvalid = 1'b1;
        m_axis_tuser  = 1'b1;
        m_axis_tlast  = 1'b1;
        grant         = owner_q ? 2'b10 : 2'b01;
      end
      FLUSH: begin
        s0_axis_tready = ~owner_q;
        s1_axis_tready = owner_q;
        grant          = owner_q ? 2'b10 : 2'b01;
      end
`endif
      default: ;
    endcase
  end

  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;

endmodule
